// File: rtl/rf_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rf_pkg
// Shared sizing and types for the register file slice.
//   DATA_W      : register, bus and extended-immediate width
//   ADDR_W      : register-index width
//   IMM_W       : raw immediate field width
//   NUM_REGS    : number of architectural registers (2**ADDR_W)
//   reg_array_t : the register storage array at default sizing
//   comp_src_e  : comparator B-operand selection
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int IMM_W    = 6;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] reg_array_t [NUM_REGS];

  // Encoding matches the CompSrc pin: 0 compares against Bus1, 1 against zero.
  typedef enum logic {
    CMP_BUS1 = 1'b0,
    CMP_ZERO = 1'b1
  } comp_src_e;

endpackage : rf_pkg

// File: rtl/register_file_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// register_file_if
// Bundles the register-file read/write, extender and comparator signals.
//   Rs1, Rs2  : read-port register indices
//   Rd        : write-destination index
//   RegWr     : write enable
//   WBbus     : write data
//   Bus1/Bus2 : read-port data
//   imm_in    : raw immediate, ExtOp selects sign (1) or zero (0) extension
//   imm_out   : extended immediate
//   CompSrc   : comparator B operand, 0 = Bus1, 1 = zero
//   comp_res  : Bus2 == selected operand
// Modports: master drives the requests, slave is the register file.
// ---------------------------------------------------------------------------
interface register_file_if #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int IMM_W  = rf_pkg::IMM_W
);

  logic [ADDR_W-1:0] Rs1;
  logic [ADDR_W-1:0] Rs2;
  logic [ADDR_W-1:0] Rd;
  logic              RegWr;
  logic [DATA_W-1:0] WBbus;
  logic [DATA_W-1:0] Bus1;
  logic [DATA_W-1:0] Bus2;
  logic [IMM_W-1:0]  imm_in;
  logic              ExtOp;
  logic [DATA_W-1:0] imm_out;
  logic              CompSrc;
  logic              comp_res;

  modport master (
    output Rs1, Rs2, Rd, RegWr, WBbus, imm_in, ExtOp, CompSrc,
    input  Bus1, Bus2, imm_out, comp_res
  );

  modport slave (
    input  Rs1, Rs2, Rd, RegWr, WBbus, imm_in, ExtOp, CompSrc,
    output Bus1, Bus2, imm_out, comp_res
  );

endinterface : register_file_if

// File: rtl/extender.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// extender
// Widens an IMM_W-bit immediate to DATA_W bits. Purely combinational.
//   imm_in  : raw immediate field
//   ext_op  : 1 = sign-extend, 0 = zero-extend
//   imm_out : extended immediate
// ---------------------------------------------------------------------------
module extender #(
  parameter int IMM_W  = rf_pkg::IMM_W,
  parameter int DATA_W = rf_pkg::DATA_W
) (
  input  logic [IMM_W-1:0]  imm_in,
  input  logic              ext_op,
  output logic [DATA_W-1:0] imm_out
);

  localparam int PAD_W = DATA_W - IMM_W;

  // Fill bit is the immediate MSB only when sign extension is requested.
  logic fill;
  assign fill = ext_op & imm_in[IMM_W-1];

  assign imm_out = {{PAD_W{fill}}, imm_in};

endmodule : extender

// File: rtl/register_file.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// register_file
// 2**ADDR_W x DATA_W register file with two combinational read ports, one
// synchronous write port, a hardwired-zero register 0, an immediate
// extender and an equality comparator on the read data.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears every register
//   bus : register_file_if.slave (reads, write, extender, comparator)
// Build option:
//   RF_BYPASS_EN : when defined, a read of the register being written this
//                  cycle returns WBbus immediately (and the comparator sees
//                  the bypassed value); otherwise the old contents are read.
// ---------------------------------------------------------------------------
module register_file #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int IMM_W  = rf_pkg::IMM_W
) (
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] cmp_b;

  // Register 0 is never a legal destination, so it is excluded here once
  // and both the storage and the bypass path share the same qualifier.
  assign wr_en = bus.RegWr && (bus.Rd != '0);

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  // NOTE: the array is cleared by the asynchronous reset on purpose: reads
  // must go to zero the instant rst rises, which rules out a RAM macro and
  // makes this a flop array. Sequential state uses <= so every register
  // samples the pre-edge values of Rd/WBbus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[bus.Rd] <= bus.WBbus;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  // NOTE: each output gets its default value on the first line so every
  // path through the block assigns it and no latch is inferred; combinational
  // logic uses blocking = so the later bypass override wins.
  always_comb begin
    rd1 = (bus.Rs1 == '0) ? '0 : regs[bus.Rs1];
    rd2 = (bus.Rs2 == '0) ? '0 : regs[bus.Rs2];
`ifdef RF_BYPASS_EN
    // Reset blocks the write, so it must also block the forward path or the
    // read ports would show data that never lands in the array.
    if (wr_en && !rst && (bus.Rs1 == bus.Rd)) begin
      rd1 = bus.WBbus;
    end
    if (wr_en && !rst && (bus.Rs2 == bus.Rd)) begin
      rd2 = bus.WBbus;
    end
`endif
  end

  assign bus.Bus1 = rd1;
  assign bus.Bus2 = rd2;

  // ---------------------------------------------------------------------
  // Comparator: Bus2 against Bus1 or zero, full-width equality
  // ---------------------------------------------------------------------
  assign cmp_b = (rf_pkg::comp_src_e'(bus.CompSrc) == rf_pkg::CMP_ZERO) ? '0 : rd1;
  assign bus.comp_res = (rd2 == cmp_b);

  // ---------------------------------------------------------------------
  // Immediate extender
  // ---------------------------------------------------------------------
  extender #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_extender (
    .imm_in  (bus.imm_in),
    .ext_op  (bus.ExtOp),
    .imm_out (bus.imm_out)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_register_file
// Self-checking bench for register_file. Expected values come from bench
// constants, a small register model and a vector table; they are queued when
// stimulus is applied and compared once the outputs have settled.
// ---------------------------------------------------------------------------
module tb_register_file;
  import rf_pkg::*;

  localparam int HALF = 10;

  logic clk = 1'b0;
  logic rst;

  register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) rif ();

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  always #HALF clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef enum int {OBS_BUS1, OBS_BUS2, OBS_IMM, OBS_COMP} obs_e;

  typedef struct {
    string             name;
    obs_e              obs;
    logic [DATA_W-1:0] exp;
  } sb_item_t;

  typedef struct {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [IMM_W-1:0]  imm;
    logic              ext;
    logic              cs;
    logic [DATA_W-1:0] e_bus1;
    logic [DATA_W-1:0] e_bus2;
    logic [DATA_W-1:0] e_imm;
    logic              e_comp;
  } vec_t;

  sb_item_t   sb[$];
  reg_array_t model;
  vec_t       vecs[9];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input obs_e obs,
                            input logic [DATA_W-1:0] exp);
    sb_item_t it;
    it.name = name;
    it.obs  = obs;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  function automatic logic [DATA_W-1:0] bit_w(input logic b);
    return {{(DATA_W-1){1'b0}}, b};
  endfunction

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic settle_and_compare();
    sb_item_t          it;
    logic [DATA_W-1:0] act;
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.obs)
        OBS_BUS1: act = rif.Bus1;
        OBS_BUS2: act = rif.Bus2;
        OBS_IMM:  act = rif.imm_out;
        default:  act = bit_w(rif.comp_res);
      endcase
      check(it.name, act, it.exp);
    end
  endtask

  // Drive read addresses and queue expectations from the register model.
  task automatic drive_reads(input string tag, input int rs1, input int rs2,
                             input logic cs);
    logic [DATA_W-1:0] e1, e2;
    rif.Rs1     = ADDR_W'(rs1);
    rif.Rs2     = ADDR_W'(rs2);
    rif.CompSrc = cs;
    e1 = model[rs1];
    e2 = model[rs2];
    expect_out({tag, ".bus1"}, OBS_BUS1, e1);
    expect_out({tag, ".bus2"}, OBS_BUS2, e2);
    expect_out({tag, ".comp"}, OBS_COMP, bit_w(e2 == (cs ? '0 : e1)));
  endtask

  task automatic write_reg(input int rd, input logic [DATA_W-1:0] data);
    @(negedge clk);
    rif.Rd    = ADDR_W'(rd);
    rif.WBbus = data;
    rif.RegWr = 1'b1;
    @(posedge clk);
    #1;
    rif.RegWr = 1'b0;
    if (rd != 0) model[rd] = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    rst         = 1'b1;
    rif.Rs1     = '0;
    rif.Rs2     = '0;
    rif.Rd      = '0;
    rif.RegWr   = 1'b0;
    rif.WBbus   = '0;
    rif.imm_in  = '0;
    rif.ExtOp   = 1'b0;
    rif.CompSrc = 1'b0;

    // ---- reset state -------------------------------------------------
    drive_reads("reset", 7, 3, 1'b0);
    settle_and_compare();
    @(negedge clk);
    rst = 1'b0;

    // ---- every read-address pair after reset -------------------------
    for (int a = 0; a < NUM_REGS; a++) begin
      for (int b = 0; b < NUM_REGS; b++) begin
        @(negedge clk);
        drive_reads($sformatf("zero[%0d,%0d]", a, b), a, b, 1'b0);
        settle_and_compare();
      end
    end

    // ---- basic write / read, register 0 ignored ----------------------
    write_reg(3, 16'hBEEF);
    rif.Rs1 = 3'd3;
    expect_out("wr3.bus1", OBS_BUS1, 16'hBEEF);
    settle_and_compare();
    write_reg(0, 16'h1234);
    rif.Rs2 = 3'd0;
    expect_out("wr0.bus2", OBS_BUS2, 16'h0000);
    settle_and_compare();

    // ---- extender ----------------------------------------------------
    rif.imm_in = 6'b100101;
    rif.ExtOp  = 1'b1;
    expect_out("ext.sign", OBS_IMM, 16'hFFE5);
    settle_and_compare();
    rif.ExtOp = 1'b0;
    expect_out("ext.zero", OBS_IMM, 16'h0025);
    settle_and_compare();

    // ---- comparator --------------------------------------------------
    write_reg(2, 16'h00AA);
    write_reg(5, 16'h00AA);
    rif.Rs1 = 3'd2; rif.Rs2 = 3'd5; rif.CompSrc = 1'b0;
    expect_out("cmp.eq", OBS_COMP, bit_w(1'b1));
    settle_and_compare();
    write_reg(5, 16'h0000);
    rif.CompSrc = 1'b1;
    expect_out("cmp.zero", OBS_COMP, bit_w(1'b1));
    settle_and_compare();
    write_reg(5, 16'h0001);
    expect_out("cmp.nonzero", OBS_COMP, bit_w(1'b0));
    settle_and_compare();

    // ---- vector table ------------------------------------------------
    write_reg(1, 16'h8001);
    write_reg(2, 16'h00AA);
    write_reg(3, 16'hBEEF);
    write_reg(4, 16'h7FFF);
    write_reg(5, 16'h0001);
    write_reg(6, 16'hFFFF);
    write_reg(7, 16'h00AA);
    vecs[0] = '{3'd1, 3'd6, 6'b011111, 1'b1, 1'b0, 16'h8001, 16'hFFFF, 16'h001F, 1'b0};
    vecs[1] = '{3'd2, 3'd7, 6'b100000, 1'b1, 1'b0, 16'h00AA, 16'h00AA, 16'hFFE0, 1'b1};
    vecs[2] = '{3'd3, 3'd3, 6'b100000, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF, 16'h0020, 1'b1};
    vecs[3] = '{3'd4, 3'd0, 6'b111111, 1'b1, 1'b1, 16'h7FFF, 16'h0000, 16'hFFFF, 1'b1};
    vecs[4] = '{3'd0, 3'd0, 6'b000000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{3'd5, 3'd4, 6'b111111, 1'b0, 1'b1, 16'h0001, 16'h7FFF, 16'h003F, 1'b0};
    vecs[6] = '{3'd6, 3'd1, 6'b000001, 1'b1, 1'b0, 16'hFFFF, 16'h8001, 16'h0001, 1'b0};
    vecs[7] = '{3'd7, 3'd2, 6'b101010, 1'b1, 1'b1, 16'h00AA, 16'h00AA, 16'hFFEA, 1'b0};
    vecs[8] = '{3'd1, 3'd5, 6'b010101, 1'b1, 1'b0, 16'h8001, 16'h0001, 16'h0015, 1'b0};
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      rif.Rs1     = vecs[v].rs1;
      rif.Rs2     = vecs[v].rs2;
      rif.imm_in  = vecs[v].imm;
      rif.ExtOp   = vecs[v].ext;
      rif.CompSrc = vecs[v].cs;
      expect_out($sformatf("vec%0d.bus1", v), OBS_BUS1, vecs[v].e_bus1);
      expect_out($sformatf("vec%0d.bus2", v), OBS_BUS2, vecs[v].e_bus2);
      expect_out($sformatf("vec%0d.imm", v),  OBS_IMM,  vecs[v].e_imm);
      expect_out($sformatf("vec%0d.comp", v), OBS_COMP, bit_w(vecs[v].e_comp));
      settle_and_compare();
    end

    // ---- same-cycle write and read of register 4 ---------------------
    @(negedge clk);
    rif.Rs1 = 3'd4; rif.Rs2 = 3'd3; rif.CompSrc = 1'b0;
    rif.Rd = 3'd4; rif.WBbus = 16'h5555; rif.RegWr = 1'b1;
`ifdef RF_BYPASS_EN
    expect_out("same.bus1", OBS_BUS1, 16'h5555);
`else
    expect_out("same.bus1", OBS_BUS1, 16'h7FFF);
`endif
    expect_out("same.bus2", OBS_BUS2, 16'hBEEF);
    settle_and_compare();
    @(posedge clk);
    #1;
    rif.RegWr = 1'b0;
    model[4] = 16'h5555;
    expect_out("same.after", OBS_BUS1, 16'h5555);
    settle_and_compare();

    // Writing register 0 never forwards.
    @(negedge clk);
    rif.Rs1 = 3'd0; rif.Rd = 3'd0; rif.WBbus = 16'h1234; rif.RegWr = 1'b1;
    expect_out("r0fwd.bus1", OBS_BUS1, 16'h0000);
    settle_and_compare();
    @(posedge clk);
    #1;
    rif.RegWr = 1'b0;

    // RegWr low: nothing forwards and nothing changes across an edge.
    @(negedge clk);
    rif.Rs1 = 3'd4; rif.Rd = 3'd4; rif.WBbus = 16'hAAAA; rif.RegWr = 1'b0;
    expect_out("nowr.pre", OBS_BUS1, 16'h5555);
    settle_and_compare();
    @(posedge clk);
    #1;
    expect_out("nowr.post", OBS_BUS1, 16'h5555);
    settle_and_compare();

    // ---- mid-cycle asynchronous reset --------------------------------
    for (int i = 1; i < NUM_REGS; i++) write_reg(i, DATA_W'(16'h1111 * i));
    @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    // Eight 1 ns samples fit before the next rising edge.
    for (int i = 0; i < NUM_REGS; i++) begin
      drive_reads($sformatf("arst[%0d]", i), i, NUM_REGS - 1 - i, 1'b0);
      settle_and_compare();
    end

    // Writes are blocked while reset is held; the extender keeps working.
    @(negedge clk);
    rif.Rd = 3'd1; rif.WBbus = 16'hFFFF; rif.RegWr = 1'b1;
    rif.Rs1 = 3'd1; rif.Rs2 = 3'd1;
    rif.imm_in = 6'b100101; rif.ExtOp = 1'b1;
    expect_out("rsthold.fwd", OBS_BUS1, 16'h0000);
    expect_out("rsthold.imm", OBS_IMM, 16'hFFE5);
    settle_and_compare();
    @(posedge clk);
    #1;
    expect_out("rsthold.bus1", OBS_BUS1, 16'h0000);
    expect_out("rsthold.bus2", OBS_BUS2, 16'h0000);
    settle_and_compare();

    // First write lands on the first rising edge after release.
    @(negedge clk);
    rst = 1'b0;
    rif.WBbus = 16'hC0DE;
    @(posedge clk);
    #1;
    rif.RegWr = 1'b0;
    expect_out("release.bus1", OBS_BUS1, 16'hC0DE);
    settle_and_compare();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The parameter DATA_W SHALL default to 16 and set the register, bus and extender output width.
REQ-002 The parameter ADDR_W SHALL default to 3 and set the register-index width, giving 2**ADDR_W = 8 registers.
REQ-003 The parameter IMM_W SHALL default to 6 and set the extender input width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The port clk SHALL be an input, 1 bit wide, and serve as the single clock, rising-edge active.
REQ-006 The port rst SHALL be an input, 1 bit wide, and serve as the asynchronous, active-high reset.
REQ-007 The port Rs1 SHALL be an input, ADDR_W bits wide, and select the register for read port 1.
REQ-008 The port Rs2 SHALL be an input, ADDR_W bits wide, and select the register for read port 2.
REQ-009 The port Rd SHALL be an input, ADDR_W bits wide, and select the write-destination register.
REQ-010 The port RegWr SHALL be an input, 1 bit wide, and enable the register write.
REQ-011 The port WBbus SHALL be an input, DATA_W bits wide, and carry the write data.
REQ-012 The port Bus1 SHALL be an output, DATA_W bits wide, and carry the read-port-1 data.
REQ-013 The port Bus2 SHALL be an output, DATA_W bits wide, and carry the read-port-2 data.
REQ-014 The port imm_in SHALL be an input, IMM_W bits wide, and carry the raw immediate field.
REQ-015 The port ExtOp SHALL be an input, 1 bit wide, and select extension: 1 = sign, 0 = zero.
REQ-016 The port imm_out SHALL be an output, DATA_W bits wide, and carry the extended immediate.
REQ-017 The port CompSrc SHALL be an input, 1 bit wide, and select the comparator B operand: 0 = Bus1, 1 = constant zero.
REQ-018 The port comp_res SHALL be an output, 1 bit wide, and be 1 when Bus2 equals the selected operand.

Function
REQ-019 Bus1 and Bus2 SHALL be combinational reads of the registers at Rs1 and Rs2, with zero-cycle latency.
REQ-020 On a rising clk edge with RegWr=1 and Rd!=0, register[Rd] SHALL be loaded with WBbus.
REQ-021 Register 0 SHALL always read 0, and writes to register 0 SHALL be ignored.
REQ-022 With RegWr=0, no register SHALL change.
REQ-023 When Rs1 equals Rs2, both read ports SHALL return the same value.
REQ-024 imm_out SHALL equal imm_in sign-extended to DATA_W when ExtOp=1, and zero-extended when ExtOp=0; it is combinational.
REQ-025 comp_res SHALL be computed as (Bus2 == (CompSrc ? 0 : Bus1)), combinationally and as a full DATA_W equality.
REQ-026 When a read address equals Rd while a write is pending in the same cycle, the read SHALL return the old value unless RF_BYPASS_EN is defined.

Reset
REQ-027 Asserting rst SHALL immediately clear all registers to 0, regardless of clk.
REQ-028 While rst is high, writes SHALL be blocked, and Bus1, Bus2 and comp_res SHALL reflect the zeroed registers.
REQ-029 Deasserting rst SHALL allow the first write on the next rising edge.
REQ-030 imm_out SHALL be unaffected by rst.

Configuration
REQ-031 When the macro RF_BYPASS_EN is defined, a read with address == Rd, RegWr=1 and Rd!=0 SHALL return WBbus combinationally in the same cycle, and comp_res SHALL use the bypassed values.
REQ-032 When RF_BYPASS_EN is undefined, no bypass SHALL exist and REQ-026 SHALL apply.

Structure
REQ-033 The package rf_pkg SHALL hold DATA_W, ADDR_W, IMM_W, NUM_REGS and the register-array typedef.
REQ-034 The extender SHALL be a single sub-module named extender; the storage and comparator SHALL be inline logic.

Verification
REQ-035 The bench SHALL apply rst, then read all Rs1/Rs2 combinations -> Bus1 = Bus2 = 0 and comp_res = 1 (CompSrc=0).
REQ-036 The bench SHALL write 16'hBEEF to register 3 and then read Rs1=3 -> Bus1 = 16'hBEEF; it SHALL write 16'h1234 to register 0 and then read Rs2=0 -> Bus2 = 0.
REQ-037 The bench SHALL apply imm_in = 6'b100101 -> imm_out = 16'hFFE5 with ExtOp=1, and 16'h0025 with ExtOp=0.
REQ-038 The bench SHALL set register 2 = register 5 = 16'h00AA -> comp_res = 1 with CompSrc=0; then set register 5 = 0 with Rs2=5 and CompSrc=1 -> comp_res = 1; a nonzero register 5 SHALL give comp_res = 0.
REQ-039 The bench SHALL drive RegWr=1, Rd=4, WBbus=16'h5555 and Rs1=4 in the same cycle -> Bus1 = 16'h5555 before the edge with RF_BYPASS_EN, and the old value without it.
REQ-040 The bench SHALL assert rst mid-cycle after writes to registers 1..7 -> all reads return 0 immediately, with no clk edge.
